// File: rtl/bird_pkg.sv
// Shared definitions for the bird game: control state encodings, screen and
// bird geometry, and datapath widths. Imported by the control FSM, the
// datapath and the draw logic.
package bird_pkg;

  typedef enum logic [2:0] {
    B_READY   = 3'b000,
    B_START   = 3'b010,
    B_RAISING = 3'b110,
    B_FALLING = 3'b011,
    B_STOP    = 3'b001
  } bird_state_e;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned Y_W     = 7;
  localparam int unsigned X_W     = 8;
  localparam int unsigned VEL_W   = 4;
  localparam int unsigned SCORE_W = 8;
  // Wide enough that pipe_x + PIPE_W and bird_y + vel never wrap
  localparam int unsigned ARITH_W = 9;

  localparam int unsigned BIRD_X  = 20;
  localparam int unsigned BIRD_W  = 4;
  localparam int unsigned BIRD_H  = 4;
  localparam int unsigned Y_START = 56;
  localparam int unsigned Y_MAX   = SCREEN_H - BIRD_H;
  localparam int unsigned PIPE_W  = 8;
  localparam int unsigned GAP_H   = 32;

  localparam logic signed [VEL_W-1:0] FLAP_VEL = -4'sd3;
  localparam logic signed [VEL_W-1:0] GRAVITY  = 4'sd1;
  localparam logic signed [VEL_W-1:0] VMAX     = 4'sd4;

endpackage

// File: rtl/bird_collide.sv
// Combinational collision detect for the bird against ceiling, floor and the
// current pipe.
//   bird_y     : registered bird top row
//   pipe_x     : left column of the current pipe
//   pipe_gap_y : top row of the pipe gap
//   hit        : any collision this cycle
module bird_collide
  import bird_pkg::*;
(
  input  logic [Y_W-1:0] bird_y,
  input  logic [X_W-1:0] pipe_x,
  input  logic [Y_W-1:0] pipe_gap_y,
  output logic           hit
);

  logic [ARITH_W-1:0] px;
  logic [ARITH_W-1:0] by;
  logic [ARITH_W-1:0] gy;
  logic               ceil_hit;
  logic               floor_hit;
  logic               h_overlap;
  logic               v_miss;

  assign px = ARITH_W'(pipe_x);
  assign by = ARITH_W'(bird_y);
  assign gy = ARITH_W'(pipe_gap_y);

  assign ceil_hit  = (bird_y == '0);
  assign floor_hit = (bird_y == Y_W'(Y_MAX));

  // Pipe columns [px, px+PIPE_W-1] intersect bird columns [BIRD_X, BIRD_X+BIRD_W-1]
  assign h_overlap = (px <= ARITH_W'(BIRD_X + BIRD_W - 1)) &&
                     ((px + ARITH_W'(PIPE_W - 1)) >= ARITH_W'(BIRD_X));

  // Bird rows not fully inside the gap rows
  assign v_miss = (by < gy) ||
                  ((by + ARITH_W'(BIRD_H - 1)) > (gy + ARITH_W'(GAP_H - 1)));

  assign hit = ceil_hit || floor_hit || (h_overlap && v_miss);

endmodule

// File: rtl/bird_datapath.sv
// Bird datapath: tracks vertical position, velocity and score per frame tick,
// and flags collisions for the control FSM.
//   clk, resetn : clock, async active-low reset
//   state       : control FSM state (bird_state_e encoding)
//   frame_tick  : one-clk pulse per frame, motion advances only here
//   pipe_x      : left column of the current pipe
//   pipe_gap_y  : top row of the current pipe gap
//   bird_y      : bird top row (registered)
//   touched     : sticky collision flag (registered)
//   score       : pipes passed, saturating (registered)
module bird_datapath
  import bird_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic [2:0]         state,
  input  logic               frame_tick,
  input  logic [X_W-1:0]     pipe_x,
  input  logic [Y_W-1:0]     pipe_gap_y,
  output logic [Y_W-1:0]     bird_y,
  output logic               touched,
  output logic [SCORE_W-1:0] score
);

  bird_state_e               st;
  logic signed [VEL_W-1:0]   vel;
  logic                      passed;

  logic [Y_W-1:0]            y_d;
  logic signed [VEL_W-1:0]   vel_d;
  logic                      touched_d;
  logic [SCORE_W-1:0]        score_d;
  logic                      passed_d;

  logic signed [VEL_W:0]     vel_inc;
  logic signed [VEL_W-1:0]   vel_n;
  logic signed [ARITH_W-1:0] y_sum;
  logic [Y_W-1:0]            y_n;
  logic [ARITH_W-1:0]        px;
  logic                      pipe_passed;
  logic                      pipe_new;
  logic                      hit;

  assign st = bird_state_e'(state);

  bird_collide u_collide (
    .bird_y     (bird_y),
    .pipe_x     (pipe_x),
    .pipe_gap_y (pipe_gap_y),
    .hit        (hit)
  );

  // Next velocity: flap, or gravity capped at VMAX (5-bit to see the overshoot)
  always_comb begin
    vel_inc = $signed({vel[VEL_W-1], vel}) + $signed({GRAVITY[VEL_W-1], GRAVITY});
    vel_n   = vel;
    if (st == B_RAISING) begin
      vel_n = FLAP_VEL;
    end else if (vel_inc > $signed({VMAX[VEL_W-1], VMAX})) begin
      vel_n = VMAX;
    end else begin
      vel_n = vel_inc[VEL_W-1:0];
    end
  end

  // Next position clamped to the playfield
  always_comb begin
    y_sum = $signed({2'b00, bird_y}) + $signed({{(ARITH_W-VEL_W){vel_n[VEL_W-1]}}, vel_n});
    y_n   = y_sum[Y_W-1:0];
    if (y_sum < $signed(ARITH_W'(0))) begin
      y_n = '0;
    end else if (y_sum > $signed(ARITH_W'(Y_MAX))) begin
      y_n = Y_W'(Y_MAX);
    end
  end

  // Pipe position relative to the bird column
  assign px          = ARITH_W'(pipe_x);
  assign pipe_passed = (px + ARITH_W'(PIPE_W - 1)) < ARITH_W'(BIRD_X);
  assign pipe_new    = px > ARITH_W'(BIRD_X + BIRD_W - 1);

  // Per-state next values for all datapath registers
  always_comb begin
    y_d       = bird_y;
    vel_d     = vel;
    touched_d = touched;
    score_d   = score;
    passed_d  = passed;
    case (st)
      B_START: begin
        y_d       = Y_W'(Y_START);
        vel_d     = '0;
        touched_d = 1'b0;
        score_d   = '0;
        passed_d  = 1'b0;
      end
      B_RAISING, B_FALLING: begin
        touched_d = touched | hit;
        // A collision freezes motion and scoring until READY/START
        if (frame_tick && !touched) begin
          y_d   = y_n;
          vel_d = vel_n;
          if (pipe_passed && !passed) begin
            score_d  = (score == '1) ? score : score + SCORE_W'(1);
            passed_d = 1'b1;
          end
          if (pipe_new) begin
            passed_d = 1'b0;
          end
        end
      end
      B_STOP: begin
      end
      default: begin
        y_d       = Y_W'(Y_START);
        vel_d     = '0;
        touched_d = 1'b0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bird_y  <= Y_W'(Y_START);
      vel     <= '0;
      touched <= 1'b0;
      score   <= '0;
      passed  <= 1'b0;
    end else begin
      bird_y  <= y_d;
      vel     <= vel_d;
      touched <= touched_d;
      score   <= score_d;
      passed  <= passed_d;
    end
  end

endmodule

// File: tb/tb_bird_datapath.sv
// Directed self-checking bench for bird_datapath.
module tb_bird_datapath;
  import bird_pkg::*;

  logic       clk;
  logic       resetn;
  logic [2:0] state;
  logic       frame_tick;
  logic [7:0] pipe_x;
  logic [6:0] pipe_gap_y;
  logic [6:0] bird_y;
  logic       touched;
  logic [7:0] score;

  int total;
  int bad;

  bird_datapath dut (
    .clk        (clk),
    .resetn     (resetn),
    .state      (state),
    .frame_tick (frame_tick),
    .pipe_x     (pipe_x),
    .pipe_gap_y (pipe_gap_y),
    .bird_y     (bird_y),
    .touched    (touched),
    .score      (score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    int exp_y;
    total      = 0;
    bad        = 0;
    resetn     = 1'b0;
    state      = B_READY;
    frame_tick = 1'b0;
    pipe_x     = 8'd150;
    pipe_gap_y = 7'd40;
    step();
    step();
    chk("rst_y", int'(bird_y), 56);
    chk("rst_touched", int'(touched), 0);
    chk("rst_score", int'(score), 0);
    resetn = 1'b1;
    step();

    // Gravity and VMAX saturation
    state = B_FALLING;
    tick(); chk("grav_1", int'(bird_y), 57);
    tick(); chk("grav_2", int'(bird_y), 59);
    tick(); chk("grav_3", int'(bird_y), 62);
    tick(); chk("grav_4", int'(bird_y), 66);
    tick(); chk("grav_5", int'(bird_y), 70);
    step(); step();
    chk("grav_hold", int'(bird_y), 70);
    tick(); chk("grav_vmax", int'(bird_y), 74);
    chk("grav_touched", int'(touched), 0);

    // Score: pipe sweeps past the bird column
    state = B_READY; step();
    chk("ready_y", int'(bird_y), 56);
    state = B_START; step();
    state = B_FALLING;
    pipe_x = 8'd30; tick(); chk("sc_30", int'(score), 0);
    pipe_x = 8'd25; tick(); chk("sc_25", int'(score), 0);
    pipe_x = 8'd20; tick(); chk("sc_20", int'(score), 0);
    pipe_x = 8'd15; tick(); chk("sc_15", int'(score), 0);
    chk("sc_15_y", int'(bird_y), 66);
    pipe_x = 8'd12; tick(); chk("sc_12", int'(score), 1);
    pipe_x = 8'd11; tick(); chk("sc_11", int'(score), 1);
    tick(); chk("sc_11b", int'(score), 1);
    pipe_x = 8'd150; tick(); chk("sc_150", int'(score), 1);
    pipe_x = 8'd12; tick(); chk("sc_second", int'(score), 2);
    chk("sc_touched", int'(touched), 0);
    chk("sc_y", int'(bird_y), 86);
    state = B_READY; step();
    chk("ready_score_hold", int'(score), 2);
    chk("ready_y2", int'(bird_y), 56);
    state = B_START; step();
    chk("start_score", int'(score), 0);

    // Asynchronous reset mid-flight
    state = B_FALLING;
    pipe_x = 8'd150; tick(); tick();
    pipe_x = 8'd12; tick();
    chk("pre_rst_y", int'(bird_y), 62);
    chk("pre_rst_score", int'(score), 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_y", int'(bird_y), 56);
    chk("arst_touched", int'(touched), 0);
    chk("arst_score", int'(score), 0);
    state = B_READY;
    #2 resetn = 1'b1;
    step();

    // Ceiling
    pipe_x = 8'd150;
    state = B_START; step();
    state = B_RAISING;
    exp_y = 56;
    for (int i = 0; i < 18; i++) begin
      tick();
      exp_y = exp_y - 3;
    end
    chk("ceil_y2", int'(bird_y), 2);
    chk("ceil_y2_touched", int'(touched), 0);
    tick(); chk("ceil_clamp", int'(bird_y), 0);
    chk("ceil_pre_touch", int'(touched), 0);
    step(); chk("ceil_touched", int'(touched), 1);
    tick(); tick(); chk("ceil_frozen", int'(bird_y), 0);
    chk("ceil_sticky", int'(touched), 1);

    // Floor
    state = B_READY; step();
    chk("ready_clear", int'(touched), 0);
    state = B_FALLING;
    for (int i = 0; i < 15; i++) tick();
    chk("floor_110", int'(bird_y), 110);
    tick(); chk("floor_114", int'(bird_y), 114);
    tick(); chk("floor_clamp", int'(bird_y), 116);
    chk("floor_pre_touch", int'(touched), 0);
    step(); chk("floor_touched", int'(touched), 1);
    state = B_STOP;
    tick(); tick();
    chk("stop_y", int'(bird_y), 116);
    chk("stop_touched", int'(touched), 1);
    state = B_READY; step();
    chk("floor_ready_y", int'(bird_y), 56);
    chk("floor_ready_t", int'(touched), 0);

    // Pipe overlap: bird outside the gap
    pipe_x = 8'd18; pipe_gap_y = 7'd70;
    state = B_FALLING; step();
    chk("pipe_hit", int'(touched), 1);
    tick(); chk("pipe_inhibit", int'(bird_y), 56);
    // Pipe overlap: bird inside the gap
    state = B_READY; step();
    chk("pipe_ready", int'(touched), 0);
    pipe_gap_y = 7'd50;
    state = B_FALLING;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("pipe_gap_ok", int'(touched), 0);
    end
    chk("pipe_gap_y", int'(bird_y), 56);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bird_datapath.md
Name: bird_datapath

Overview:
- Datapath partner of the bird control FSM.
- Consumes the control's 3-bit state and a per-frame tick, and maintains bird vertical position, velocity and score.
- Produces the `touched` (collision) signal that the control FSM consumes to enter STOP.
- Sits between the control FSM, the pipe generator (pipe_x, pipe_gap_y) and the VGA draw logic (bird_y, score).

Parameters:
- SCREEN_H, 120, playfield height in pixels (VGA 160x120)
- BIRD_X, 20, fixed left column of the bird
- BIRD_W, 4, bird width
- BIRD_H, 4, bird height
- Y_START, 56, bird top row in READY/START
- FLAP_VEL, -3, signed velocity loaded on each RAISING tick
- GRAVITY, 1, velocity increment per FALLING tick
- VMAX, 4, maximum downward velocity
- PIPE_W, 8, pipe width
- GAP_H, 32, vertical gap height of a pipe

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- state  in  3  control FSM state: READY=000, START=010, RAISING=110, FALLING=011, STOP=001
- frame_tick  in  1  one-clk pulse per frame; motion advances only on this pulse
- pipe_x  in  8  left column of current pipe (0..159)
- pipe_gap_y  in  7  top row of the pipe gap
- bird_y  out  7  bird top row
- touched  out  1  registered, sticky collision flag
- score  out  8  pipes passed, saturating at 255

Behaviour:
- Reset is asynchronous and active-low (`resetn`); the single clock is `clk`.
- Reset values: bird_y=Y_START, vel=0 (signed 4-bit internal), touched=0, score=0, passed flag=0.
  - Reset applies immediately on resetn falling, with no clk edge needed, and may occur mid-flight.
- READY and any unlisted encoding: bird_y=Y_START, vel=0, touched=0. Score is held.
- START: bird_y=Y_START, vel=0, touched=0, score=0, passed=0.
- RAISING or FALLING, with touched=0, on a clk edge where frame_tick=1:
  - RAISING: vel_n = FLAP_VEL.
  - FALLING: vel_n = min(vel+GRAVITY, VMAX).
  - y_n = clamp(bird_y + vel_n, 0, SCREEN_H-BIRD_H). Arithmetic is 9-bit signed to avoid wrap.
  - vel <= vel_n; bird_y <= y_n. Latency is one clk from tick to new bird_y.
  - With frame_tick=0, all values are held.
- Collision is evaluated each clk in RAISING/FALLING on the registered bird_y and the current pipe inputs. It is true if any of:
  - bird_y==0 (ceiling)
  - bird_y==SCREEN_H-BIRD_H (floor)
  - horizontal overlap (pipe_x <= BIRD_X+BIRD_W-1 and pipe_x+PIPE_W-1 >= BIRD_X) and vertical miss (bird_y < pipe_gap_y or bird_y+BIRD_H-1 > pipe_gap_y+GAP_H-1)
- touched: registered; set the clk after collision becomes true.
  - Sticky through RAISING/FALLING/STOP; cleared only in READY, START or reset.
  - While touched=1, position and velocity updates are inhibited, even if frame_tick arrives before the control reaches STOP.
- STOP: bird_y, vel, score and touched are frozen.
- Score, updated on frame_tick in RAISING/FALLING with touched=0:
  - If pipe_x+PIPE_W-1 < BIRD_X and passed=0: score <= sat(score+1) and passed <= 1.
  - If pipe_x > BIRD_X+BIRD_W-1 (new pipe): passed <= 0.
  - Pipe arithmetic is 9 bits, so pipe_x+PIPE_W does not wrap.
- Simultaneous events:
  - Collision and pass on the same tick: position update and score increment both apply; touched sets next clk.
  - State change and frame_tick in the same cycle: the rules of the current (incoming) state apply.

Decomposition:
- Package bird_pkg:
  - state encodings B_READY/B_START/B_RAISING/B_FALLING/B_STOP
  - SCREEN_W=160, SCREEN_H=120
  - Y and X width constants
  - shared with the control FSM and the draw logic
- One combinational sub-module, bird_collide: inputs bird_y, pipe_x, pipe_gap_y; output hit. Carries the ceiling/floor/pipe-overlap rules above.
- Velocity, position and score registers stay in bird_datapath.

Test Plan:
- Reset mid-flight: FALLING with bird_y=30, vel=2; drop resetn between clk edges -> bird_y=56, touched=0, score=0 immediately.
- Gravity/VMAX: FALLING from 56, vel 0, pipe_x=150, 5 ticks -> bird_y 57,59,62,66,70; vel saturates at 4.
- Ceiling: RAISING from 56, ticks -> 53,50,...,2, then 0 (clamped); touched=1 one clk later; further ticks leave bird_y=0.
- Floor: FALLING with bird_y=110, vel=4, ticks -> 114, then 116 (clamped); touched=1 next clk; state=STOP with ticks -> frozen; state=READY -> bird_y=56, touched=0.
- Pipe: bird_y=56, pipe_x=18 -> with pipe_gap_y=70, touched=1 next clk; with pipe_gap_y=50, touched stays 0 across 10 clks.
- Score: pipe_x stepped 30 down to 11 on ticks -> score 0->1 exactly once; pipe_x=150 then stepped to 11 -> score=2; START -> score=0.
